// File: rtl/cla_vector_driver.sv
// rtl/cla_vector_driver.sv - operand driver and result checker for the carry-lookahead adder.
// Optional CLA_EXHAUSTIVE_EN swaps the LFSR operand source for an exhaustive up-counter.
module cla_vector_driver #(
  parameter int          WIDTH       = 9,
  parameter int          NUM_VECTORS = 256,
  parameter int          RESULT_LAT  = 0,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH:0]   i_dut_result,
  output logic [WIDTH-1:0] o_add1,
  output logic [WIDTH-1:0] o_add2,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [15:0]      o_err_count,
  output logic [15:0]      o_vec_count,
  output logic [WIDTH-1:0] o_fail_add1,
  output logic [WIDTH-1:0] o_fail_add2,
  output logic [WIDTH:0]   o_fail_result
);

  localparam int DL_DEPTH = (RESULT_LAT == 0) ? 1 : RESULT_LAT;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] add1;
    logic [WIDTH-1:0] add2;
    logic [WIDTH:0]   expected;
  } dl_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] add1_q, add1_d, add2_q, add2_d;
  logic [1:0]       drain_q, drain_d;
  logic [15:0]      vec_q, vec_d, err_q, err_d;
  logic             failed_q, failed_d;
  logic [WIDTH-1:0] fail_add1_q, fail_add1_d, fail_add2_q, fail_add2_d;
  logic [WIDTH:0]   fail_res_q, fail_res_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  dl_t              dl_q [DL_DEPTH];
  dl_t              dl_d [DL_DEPTH];
  dl_t              ent, cmp;
  logic             start_go;
  logic             last_issue;

`ifdef CLA_EXHAUSTIVE_EN
  localparam int               SRC_W    = 2 * WIDTH;
  localparam logic [SRC_W-1:0] SRC_INIT = '0;
  logic [SRC_W-1:0] src_q, src_d, src_next;

  assign src_next   = src_q + 1'b1;
  assign last_issue = &src_q;
`else
  localparam int          SRC_W    = 32;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [31:0] SRC_INIT = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  logic [SRC_W-1:0] src_q, src_d, src_next;
  logic [15:0]      issue_q, issue_d;

  // Right-shifting Galois LFSR; the issue counter decides run length.
  assign src_next   = (src_q >> 1) ^ (src_q[0] ? POLY : 32'd0);
  assign last_issue = (issue_q == 16'(NUM_VECTORS - 1));

  always_comb begin
    issue_d = issue_q;
    if (start_go) begin
      issue_d = '0;
    end else if (state_q == S_RUN && !last_issue) begin
      issue_d = issue_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) issue_q <= '0;
    else       issue_q <= issue_d;
  end
`endif

  assign start_go = i_start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    add1_d      = add1_q;
    add2_d      = add2_q;
    drain_d     = drain_q;
    vec_d       = vec_q;
    err_d       = err_q;
    failed_d    = failed_q;
    fail_add1_d = fail_add1_q;
    fail_add2_d = fail_add2_q;
    fail_res_d  = fail_res_q;

    ent.valid    = (state_q == S_RUN);
    ent.add1     = add1_q;
    ent.add2     = add2_q;
    ent.expected = {1'b0, add1_q} + {1'b0, add2_q};
    dl_d[0] = ent;
    for (int i = 1; i < DL_DEPTH; i++) dl_d[i] = dl_q[i-1];
    // Zero latency compares against the operands being driven right now.
    cmp = (RESULT_LAT == 0) ? ent : dl_q[DL_DEPTH-1];

    if (cmp.valid) begin
      vec_d = (vec_q == 16'hFFFF) ? vec_q : vec_q + 16'd1;
      if (i_dut_result != cmp.expected) begin
        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
        if (!failed_q) begin
          failed_d    = 1'b1;
          fail_add1_d = cmp.add1;
          fail_add2_d = cmp.add2;
          fail_res_d  = i_dut_result;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_go) begin
          state_d     = S_RUN;
          src_d       = SRC_INIT;
          add1_d      = SRC_INIT[2*WIDTH-1:WIDTH];
          add2_d      = SRC_INIT[WIDTH-1:0];
          vec_d       = '0;
          err_d       = '0;
          failed_d    = 1'b0;
          fail_add1_d = '0;
          fail_add2_d = '0;
          fail_res_d  = '0;
        end
      end
      S_RUN: begin
        if (last_issue) begin
          state_d = (RESULT_LAT == 0) ? S_DONE : S_DRAIN;
          drain_d = '0;
        end else begin
          src_d  = src_next;
          add1_d = src_next[2*WIDTH-1:WIDTH];
          add2_d = src_next[WIDTH-1:0];
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(RESULT_LAT - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == 16'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      src_q       <= SRC_INIT;
      add1_q      <= '0;
      add2_q      <= '0;
      drain_q     <= '0;
      vec_q       <= '0;
      err_q       <= '0;
      failed_q    <= 1'b0;
      fail_add1_q <= '0;
      fail_add2_q <= '0;
      fail_res_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      for (int i = 0; i < DL_DEPTH; i++) dl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      add1_q      <= add1_d;
      add2_q      <= add2_d;
      drain_q     <= drain_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      failed_q    <= failed_d;
      fail_add1_q <= fail_add1_d;
      fail_add2_q <= fail_add2_d;
      fail_res_q  <= fail_res_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      for (int i = 0; i < DL_DEPTH; i++) dl_q[i] <= dl_d[i];
    end
  end

  assign o_add1        = add1_q;
  assign o_add2        = add2_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_err_count   = err_q;
  assign o_vec_count   = vec_q;
  assign o_fail_add1   = fail_add1_q;
  assign o_fail_add2   = fail_add2_q;
  assign o_fail_result = fail_res_q;

endmodule

// File: tb/tb_cla_vector_driver.sv
// tb/tb_cla_vector_driver.sv - self-checking bench for cla_vector_driver.
module tb_cla_vector_driver;

`ifdef CLA_EXHAUSTIVE_EN
  localparam int W = 2;
`else
  localparam int W = 9;
`endif
  localparam int          NVA   = 12;
  localparam int          NVB   = 10;
  localparam int          LATB  = 2;
  localparam logic [31:0] SEEDA = 32'h0000_0001;
  localparam logic [31:0] SEEDB = 32'h0BAD_5EED;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a_add1, a_add2, a_fadd1, a_fadd2, b_add1, b_add2, b_fadd1, b_fadd2;
  logic [W:0]   a_res, a_fres, b_res, b_fres;
  logic         a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [15:0]  a_err, a_vec, b_err, b_vec;

  int           mode_a = 0;
  logic [2*W-1:0] tgt_a = '0;
  int           dly_b = 2;
  logic [W:0]   hist0 = '0, hist1 = '0;

  always_comb begin
    a_res = {1'b0, a_add1} + {1'b0, a_add2};
    if (mode_a == 1) a_res = '1;
    else if (mode_a == 2 && {a_add1, a_add2} == tgt_a) a_res = a_res ^ 1;
  end

  always @(posedge clk) begin
    hist0 <= {1'b0, b_add1} + {1'b0, b_add2};
    hist1 <= hist0;
  end
  assign b_res = (dly_b == 2) ? hist1 : hist0;

  cla_vector_driver #(.WIDTH(W), .NUM_VECTORS(NVA), .RESULT_LAT(0), .LFSR_SEED(SEEDA)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_dut_result(a_res),
    .o_add1(a_add1), .o_add2(a_add2), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_err_count(a_err), .o_vec_count(a_vec),
    .o_fail_add1(a_fadd1), .o_fail_add2(a_fadd2), .o_fail_result(a_fres));

  cla_vector_driver #(.WIDTH(W), .NUM_VECTORS(NVB), .RESULT_LAT(LATB), .LFSR_SEED(SEEDB)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_dut_result(b_res),
    .o_add1(b_add1), .o_add2(b_add2), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_err_count(b_err), .o_vec_count(b_vec),
    .o_fail_add1(b_fadd1), .o_fail_add2(b_fadd2), .o_fail_result(b_fres));

  // Reference: the i-th vector of a run and the number of vectors per run.
  function automatic logic [2*W-1:0] vec(int i, logic [31:0] seed);
`ifdef CLA_EXHAUSTIVE_EN
    logic [31:0] c = i;
    return c[2*W-1:0];
`else
    logic [31:0] s = (seed == 0) ? 32'd1 : seed;
    for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? POLY : 32'd0);
    return s[2*W-1:0];
`endif
  endfunction

  function automatic int nvec(int nv);
`ifdef CLA_EXHAUSTIVE_EN
    return 1 << (2 * W);
`else
    return nv;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one run on instance sel, checks every issued operand pair and completion latency.
  task automatic run(int sel, int n, int lat, logic [31:0] seed, bit poke);
    int idx;
    logic [2*W-1:0] v;
    if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (idx = 0; idx < 2000; idx++) begin
      if ((sel == 1 ? b_done : a_done) === 1'b1) break;
      if (idx < n) begin
        v = vec(idx, seed);
        chk($sformatf("ops[%0d]", idx), (sel == 1) ? {b_add1, b_add2} : {a_add1, a_add2}, v);
      end
      if (poke && idx == 2) start_a = 1'b1;
      if (idx == 3) start_a = 1'b0;
      @(negedge clk);
    end
    chk("latency", idx, n + lat);
  endtask

  initial begin
    int na, nb, k, exp_err, first;
    logic [2*W-1:0] v;

    na = nvec(NVA);
    nb = nvec(NVB);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_ops", {a_add1, a_add2}, 0);
    chk("rst_err", a_err, 0);
    chk("rst_vec", a_vec, 0);

    // Golden adder, then a restart from DONE with a start pulse ignored mid-run.
    for (int r = 0; r < 2; r++) begin
      run(0, na, 0, SEEDA, r == 1);
      chk("gold_done", a_done, 1);
      chk("gold_vec", a_vec, na);
      chk("gold_err", a_err, 0);
      chk("gold_pass", a_pass, 1);
      chk("gold_hold", {a_add1, a_add2}, vec(na - 1, SEEDA));
    end

    // Stuck-at-all-ones result mismatches every vector.
    mode_a = 1;
    run(0, na, 0, SEEDA, 0);
    v = vec(0, SEEDA);
    chk("stuck_err", a_err, na);
    chk("stuck_pass", a_pass, 0);
    chk("stuck_fail_ops", {a_fadd1, a_fadd2}, v);
    chk("stuck_fail_res", a_fres, {(W+1){1'b1}});

    // Fault injected on one operand pair only.
`ifdef CLA_EXHAUSTIVE_EN
    k = na - 1;
`else
    k = $urandom_range(na - 1, 0);
`endif
    tgt_a = vec(k, SEEDA);
    exp_err = 0;
    first = -1;
    for (int i = 0; i < na; i++) begin
      if (vec(i, SEEDA) == tgt_a) begin
        exp_err++;
        if (first < 0) first = i;
      end
    end
    mode_a = 2;
    run(0, na, 0, SEEDA, 0);
    chk("inj_err", a_err, exp_err);
    chk("inj_pass", a_pass, 0);
    chk("inj_fail_ops", {a_fadd1, a_fadd2}, vec(first, SEEDA));
    chk("inj_fail_res", a_fres, (tgt_a[2*W-1:W] + tgt_a[W-1:0]) ^ 1);
    mode_a = 0;

    // Latency-2 instance: correctly delayed DUT passes, under-delayed DUT fails.
    dly_b = 2;
    run(1, nb, LATB, SEEDB, 0);
    chk("lat2_vec", b_vec, nb);
    chk("lat2_err", b_err, 0);
    chk("lat2_pass", b_pass, 1);
    dly_b = 1;
    run(1, nb, LATB, SEEDB, 0);
    chk("lat1_err_nonzero", b_err != 0, 1);
    chk("lat1_pass", b_pass, 0);

    // Held start gives back-to-back runs with a single DONE cycle between.
    start_a = 1'b1;
    for (int i = 0; i < 2000 && a_done !== 1'b1; i++) @(negedge clk);
    chk("b2b_done", a_done, 1);
    @(negedge clk);
    chk("b2b_rerun_busy", a_busy, 1);
    chk("b2b_rerun_done", a_done, 0);
    start_a = 1'b0;

    // Reset in the middle of a run aborts immediately.
    repeat (3) @(negedge clk);
    chk("mid_busy", a_busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_done", a_done, 0);
    chk("midrst_ops", {a_add1, a_add2}, 0);
    chk("midrst_err", a_err, 0);
    repeat (na + 2) @(negedge clk);
    chk("midrst_idle_done", a_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
